lstm_cell_seq: RTL and testbench

//  Multi-unit LSTM cell, HIDDEN units, one scalar input per time step, using a single time-shared MAC.

---
 rtl/lstm_pkg.sv | 43 ++++
 rtl/lstm_mac.sv | 38 +++
 rtl/lstm_cell_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_lstm_cell_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types and fixed-point helpers for the sequential LSTM cell.
package lstm_pkg;

  typedef enum logic [1:0] {GATE_I, GATE_F, GATE_G, GATE_O} gate_t;
  typedef enum logic [2:0] {IDLE, MAC, ACT, UPD, OUT} state_t;

  // Wide signed scratch type; every intermediate fits comfortably for WIDTH <= 24.
  typedef logic signed [63:0] wide_t;

  localparam int NUM_GATES = 4;

  // Clamp to the signed range of a width-bit word.
  function automatic wide_t sat(input wide_t v, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // clamp(pre/4 + 0.5, 0, 1.0); the divide is an arithmetic shift, so it floors.
  function automatic wide_t hard_sigmoid(input wide_t pre, input int frac);
    wide_t one;
    wide_t s;
    one = wide_t'(1) <<< frac;
    s   = (pre >>> 2) + (one >>> 1);
    if (s > one) return one;
    if (s < wide_t'(0)) return wide_t'(0);
    return s;
  endfunction

  // clamp(pre, -1.0, 1.0)
  function automatic wide_t hard_tanh(input wide_t pre, input int frac);
    wide_t one;
    one = wide_t'(1) <<< frac;
    if (pre > one) return one;
    if (pre < -one) return -one;
    return pre;
  endfunction

endpackage

// File: rtl/lstm_mac.sv
// Time-shared signed MAC: load bias<<FRAC, accumulate one product per enabled
// cycle, and present the accumulator shifted down by FRAC and saturated.
module lstm_mac
  import lstm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ACCW  = 35
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] pre
);

  logic signed [ACCW-1:0]    acc;
  logic signed [2*WIDTH-1:0] prod;

  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

  // Accumulator: a bias load takes priority over accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACCW'(bias) <<< FRAC;
    end else if (en) begin
      acc <= acc + ACCW'(prod);
    end
  end

  assign pre = WIDTH'(sat(wide_t'(acc >>> FRAC), WIDTH));

endmodule

// File: rtl/lstm_cell_seq.sv
// Multi-unit LSTM cell sharing one MAC across all gates and units.
//
//  state | meaning
//  IDLE  | x_ready high, weight writes accepted, waiting for x_valid
//  MAC   | one product per cycle: wx*x then wh[j]*h_old[j]
//  ACT   | activate the accumulated gate, load next gate's bias
//  UPD   | compute c/h for the current unit into next-state buffers
//  OUT   | y_valid high, h/C committed, waiting for y_ready
module lstm_cell_seq
  import lstm_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int FRAC   = 8,
  parameter  int HIDDEN = 4,
  localparam int DEPTH  = HIDDEN * NUM_GATES * (HIDDEN + 2),
  localparam int AWD    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_we,
  input  logic [AWD-1:0]            w_addr,
  input  logic signed [WIDTH-1:0]   w_data,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic                      seq_start,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic [HIDDEN*WIDTH-1:0]   y_out,
  output logic [HIDDEN*WIDTH-1:0]   c_out,
  output logic                      y_valid,
  input  logic                      y_ready
);

  localparam int UW   = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
  localparam int TW   = $clog2(HIDDEN + 1);
  localparam int ACCW = 2 * WIDTH + $clog2(HIDDEN + 2);

  state_t                  state;
  gate_t                   gate;
  logic [UW-1:0]           unit;
  logic [TW-1:0]           term;
  logic                    last_unit;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] rd_data;
  int                      rd_idx;
  int                      rd_u;
  int                      rd_g;
  int                      rd_k;

  logic signed [WIDTH-1:0] x_q;
  logic                    zero_state;
  logic signed [WIDTH-1:0] i_q, f_q, g_q, o_q;

  logic [HIDDEN*WIDTH-1:0] h_old_v, c_old_v, h_nxt_v, c_nxt_v;
  logic [HIDDEN*WIDTH-1:0] h_upd_v, c_upd_v;

  logic                    mac_load;
  logic signed [WIDTH-1:0] mac_b;
  logic signed [WIDTH-1:0] mac_pre;
  logic signed [WIDTH-1:0] act_val;
  int                      h_sel;

  logic signed [WIDTH-1:0] c_old_u;
  logic signed [WIDTH-1:0] c_new;
  logic signed [WIDTH-1:0] h_new;

  assign last_unit = (int'(unit) == HIDDEN - 1);

  // Weight memory: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_we && x_ready && (int'(w_addr) < DEPTH)) begin
      mem[w_addr] <= w_data;
    end
  end

  // Weight read address: the next bias while loading, otherwise the current term.
  always_comb begin
    rd_u = int'(unit);
    rd_g = int'(gate);
    rd_k = HIDDEN + 1 - int'(term);
    case (state)
      IDLE: begin
        rd_u = 0;
        rd_g = 0;
        rd_k = 0;
      end
      ACT: begin
        rd_g = int'(gate) + 1;
        rd_k = 0;
      end
      UPD: begin
        rd_u = int'(unit) + 1;
        rd_g = 0;
        rd_k = 0;
      end
      default: ;
    endcase
    rd_idx = (rd_u * NUM_GATES + rd_g) * (HIDDEN + 2) + rd_k;
  end

  // Read port with write bypass so a write in the accepting cycle feeds that step's bias.
  always_comb begin
    rd_data = '0;
    if (rd_idx < DEPTH) begin
      if (w_we && x_ready && (int'(w_addr) == rd_idx)) rd_data = w_data;
      else rd_data = mem[rd_idx[AWD-1:0]];
    end
  end

  assign mac_load = (state == IDLE && x_valid) ||
                    (state == ACT && gate != GATE_O) ||
                    (state == UPD && !last_unit);

  // Second MAC operand: x on the first product, then h_old[j] (zero on seq_start).
  always_comb begin
    mac_b = x_q;
    h_sel = HIDDEN - 1 - int'(term);
    if (int'(term) != HIDDEN) begin
      if (zero_state) mac_b = '0;
      else mac_b = h_old_v[h_sel*WIDTH +: WIDTH];
    end
  end

  lstm_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACCW  (ACCW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .load (mac_load),
    .en   (state == MAC),
    .bias (rd_data),
    .a    (rd_data),
    .b    (mac_b),
    .pre  (mac_pre)
  );

  assign act_val = WIDTH'((gate == GATE_G) ? hard_tanh(wide_t'(mac_pre), FRAC)
                                           : hard_sigmoid(wide_t'(mac_pre), FRAC));

  // Cell update for the current unit; next-state vectors with this unit replaced.
  always_comb begin
    if (zero_state) c_old_u = '0;
    else c_old_u = c_old_v[int'(unit)*WIDTH +: WIDTH];
    c_new = WIDTH'(sat(((wide_t'(f_q) * wide_t'(c_old_u)) >>> FRAC) +
                       ((wide_t'(i_q) * wide_t'(g_q)) >>> FRAC), WIDTH));
    h_new = WIDTH'(sat((wide_t'(o_q) * hard_tanh(wide_t'(c_new), FRAC)) >>> FRAC, WIDTH));
    h_upd_v = h_nxt_v;
    c_upd_v = c_nxt_v;
    h_upd_v[int'(unit)*WIDTH +: WIDTH] = h_new;
    c_upd_v[int'(unit)*WIDTH +: WIDTH] = c_new;
  end

  // Sequencer: state, gate/unit/term counters and the handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gate    <= GATE_I;
      unit    <= '0;
      term    <= '0;
      x_ready <= 1'b1;
      y_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (x_valid) begin
            state   <= MAC;
            gate    <= GATE_I;
            unit    <= '0;
            term    <= TW'(HIDDEN);
            x_ready <= 1'b0;
          end
        end
        MAC: begin
          if (term == '0) state <= ACT;
          else term <= term - TW'(1);
        end
        ACT: begin
          if (gate == GATE_O) begin
            state <= UPD;
          end else begin
            gate  <= gate_t'(gate + 2'd1);
            term  <= TW'(HIDDEN);
            state <= MAC;
          end
        end
        UPD: begin
          if (last_unit) begin
            state   <= OUT;
            y_valid <= 1'b1;
          end else begin
            unit  <= unit + UW'(1);
            gate  <= GATE_I;
            term  <= TW'(HIDDEN);
            state <= MAC;
          end
        end
        OUT: begin
          if (y_ready) begin
            state   <= IDLE;
            y_valid <= 1'b0;
            x_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: sampled input, gate values, h/C double buffers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      zero_state <= 1'b0;
      i_q        <= '0;
      f_q        <= '0;
      g_q        <= '0;
      o_q        <= '0;
      h_old_v    <= '0;
      c_old_v    <= '0;
      h_nxt_v    <= '0;
      c_nxt_v    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (x_valid) begin
            x_q        <= x_in;
            zero_state <= seq_start;
          end
        end
        ACT: begin
          case (gate)
            GATE_I:  i_q <= act_val;
            GATE_F:  f_q <= act_val;
            GATE_G:  g_q <= act_val;
            default: o_q <= act_val;
          endcase
        end
        UPD: begin
          h_nxt_v <= h_upd_v;
          c_nxt_v <= c_upd_v;
          if (last_unit) begin
            h_old_v <= h_upd_v;
            c_old_v <= c_upd_v;
          end
        end
        default: ;
      endcase
    end
  end

  assign y_out = h_old_v;
  assign c_out = c_old_v;

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Randomized bench for lstm_cell_seq (HIDDEN=4) against a plain-arithmetic LSTM model.
module tb_lstm_cell_seq;

  localparam int W     = 16;
  localparam int F     = 8;
  localparam int H     = 4;
  localparam int DEPTH = H * 4 * (H + 2);
  localparam int AWD   = $clog2(DEPTH);
  localparam int L     = H * (4 * H + 9);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 w_we = 1'b0;
  logic [AWD-1:0]       w_addr = '0;
  logic signed [W-1:0]  w_data = '0;
  logic signed [W-1:0]  x_in = '0;
  logic                 seq_start = 1'b0;
  logic                 x_valid = 1'b0;
  logic                 x_ready;
  logic [H*W-1:0]       y_out;
  logic [H*W-1:0]       c_out;
  logic                 y_valid;
  logic                 y_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  longint wm [DEPTH];
  longint hm [H];
  longint cm [H];
  logic [H*W-1:0] exp_y;
  logic [H*W-1:0] exp_c;

  always #5 clk = ~clk;

  lstm_cell_seq #(.WIDTH(W), .FRAC(F), .HIDDEN(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .x_in      (x_in),
    .seq_start (seq_start),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .y_out     (y_out),
    .c_out     (c_out),
    .y_valid   (y_valid),
    .y_ready   (y_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint hsig(input longint p);
    longint s;
    s = (p >>> 2) + 128;
    if (s > 256) return 256;
    if (s < 0) return 0;
    return s;
  endfunction

  function automatic longint htanh(input longint p);
    if (p > 256) return 256;
    if (p < -256) return -256;
    return p;
  endfunction

  function automatic int widx(input int u, input int g, input int k);
    return ((u * 4 + g) * (H + 2)) + k;
  endfunction

  // One LSTM time step on the model state; fills exp_y/exp_c.
  task automatic model_step(input longint x, input bit ss);
    longint gv [4];
    longint hn [H];
    longint cn [H];
    longint acc;
    if (ss) begin
      for (int u = 0; u < H; u++) begin
        hm[u] = 0;
        cm[u] = 0;
      end
    end
    for (int u = 0; u < H; u++) begin
      for (int g = 0; g < 4; g++) begin
        acc = wm[widx(u, g, 0)] * 256 + wm[widx(u, g, 1)] * x;
        for (int j = 0; j < H; j++) acc += wm[widx(u, g, 2 + j)] * hm[j];
        gv[g] = (g == 2) ? htanh(sat16(acc >>> F)) : hsig(sat16(acc >>> F));
      end
      cn[u] = sat16(((gv[1] * cm[u]) >>> F) + ((gv[0] * gv[2]) >>> F));
      hn[u] = sat16((gv[3] * htanh(cn[u])) >>> F);
    end
    for (int u = 0; u < H; u++) begin
      hm[u] = hn[u];
      cm[u] = cn[u];
      exp_y[u*W +: W] = W'(hn[u]);
      exp_c[u*W +: W] = W'(cn[u]);
    end
  endtask

  task automatic write_w(input int a, input longint v);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = AWD'(a);
    w_data = W'(v);
    wm[a]  = v;
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  task automatic set_all(input longint b, input longint wx, input longint wh);
    for (int u = 0; u < H; u++)
      for (int g = 0; g < 4; g++) begin
        write_w(widx(u, g, 0), b);
        write_w(widx(u, g, 1), wx);
        for (int j = 0; j < H; j++) write_w(widx(u, g, 2 + j), wh);
      end
  endtask

  task automatic do_step(input longint x, input bit ss, input bit hold,
                         input bit wr_same, input int wa, input longint wd);
    int cyc;
    bit seen;
    @(negedge clk);
    check("x_ready_idle", x_ready, 1);
    x_in      = W'(x);
    seq_start = ss;
    x_valid   = 1'b1;
    if (wr_same) begin
      w_we   = 1'b1;
      w_addr = AWD'(wa);
      w_data = W'(wd);
      wm[wa] = wd;
    end
    @(posedge clk);
    #1;
    x_valid   = 1'b0;
    w_we      = 1'b0;
    seq_start = 1'b0;
    check("x_ready_busy", x_ready, 0);
    model_step(x, ss);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hold && cyc == 10) begin
        w_we    = 1'b1;
        w_addr  = '0;
        w_data  = 16'sh1234;
        x_valid = 1'b1;
      end else if (hold && cyc == 11) begin
        w_we    = 1'b0;
        x_valid = 1'b0;
      end
      seen = y_valid;
    end
    check("latency", cyc, L);
    check("y_out", y_out, exp_y);
    check("c_out", c_out, exp_c);
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        x_valid = 1'b1;
        check("hold_y", y_out, exp_y);
        check("hold_c", c_out, exp_c);
        check("hold_xr", x_ready, 0);
        check("hold_yv", y_valid, 1);
      end
    end
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    y_ready = 1'b0;
    check("xr_after_hs", x_ready, 1);
    check("yv_after_hs", y_valid, 0);
  endtask

  function automatic longint rnd(input int lo, input int hi);
    return longint'($urandom_range(0, hi - lo)) + lo;
  endfunction

  initial begin
    logic [H*W-1:0] k_val;
    longint x;
    bit ss;

    for (int u = 0; u < H; u++) begin
      hm[u] = 0;
      cm[u] = 0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    check("rst_x_ready", x_ready, 1);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_c_out", c_out, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed: identity input weight, no recurrence
    set_all(0, 256, 0);
    do_step(256, 1'b1, 1'b0, 1'b0, 0, 0);
    k_val = {H{16'd144}};
    check("t1_y", y_out, k_val);
    k_val = {H{16'd192}};
    check("t1_c", c_out, k_val);
    do_step(256, 1'b0, 1'b0, 1'b0, 0, 0);
    k_val = {H{16'd192}};
    check("t2_y", y_out, k_val);
    k_val = {H{16'd336}};
    check("t2_c", c_out, k_val);
    do_step(256, 1'b1, 1'b0, 1'b0, 0, 0);
    k_val = {H{16'd144}};
    check("t2r_y", y_out, k_val);

    // Saturation, both polarities
    set_all(0, 32767, 0);
    do_step(32767, 1'b1, 1'b0, 1'b0, 0, 0);
    k_val = {H{16'd256}};
    check("sat_pos_y", y_out, k_val);
    check("sat_pos_c", c_out, k_val);
    set_all(0, -32768, 0);
    do_step(32767, 1'b1, 1'b0, 1'b0, 0, 0);
    k_val = '0;
    check("sat_neg_y", y_out, k_val);
    check("sat_neg_c", c_out, k_val);

    // Random recurrence
    for (int a = 0; a < DEPTH; a++) begin
      if (a % (H + 2) == 0)      write_w(a, rnd(-256, 256));
      else if (a % (H + 2) == 1) write_w(a, rnd(-256, 256));
      else                       write_w(a, rnd(-160, 160));
    end
    for (int s = 0; s < 50; s++) begin
      if (s % 7 == 3) write_w($urandom_range(0, DEPTH - 1), rnd(-256, 256));
      x  = ($urandom_range(0, 9) == 0) ? rnd(-32768, 32767) : rnd(-512, 512);
      ss = (s == 0) || ($urandom_range(0, 7) == 0);
      do_step(x, ss, s == 10, (s == 20 || s == 30), (s == 20) ? 0 : widx(H - 1, 3, 1),
              rnd(-256, 256));
    end

    // Reset in the middle of a step
    @(negedge clk);
    x_in    = W'(rnd(-512, 512));
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    repeat (39) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_x_ready", x_ready, 1);
    check("mid_rst_y_valid", y_valid, 0);
    check("mid_rst_y_out", y_out, 0);
    check("mid_rst_c_out", c_out, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int u = 0; u < H; u++) begin
      hm[u] = 0;
      cm[u] = 0;
    end
    do_step(rnd(-512, 512), 1'b0, 1'b0, 1'b0, 0, 0);
    do_step(rnd(-512, 512), 1'b0, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
